// File: rtl/mem_bus_arb_pkg.sv
// Shared types and helpers for the memory-bus arbiter and its winner picker.
package mem_bus_arb_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SYNC      = 3'd1,
        S_WAIT_ACK  = 3'd2,
        S_WAIT_REL  = 3'd3,
        S_WAIT_DONE = 3'd4,
        S_DRAIN     = 3'd5
    } arb_state_e;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    function automatic int owner_bits(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_pick.sv
// Single-cycle winner picker: first set request at or after ptr (round-robin),
// or lowest set index (fixed). ptr must be below N.
module rr_pick
    import mem_bus_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = owner_bits(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             mode,
    output logic [IDX_W-1:0] winner,
    output logic             valid
);

    logic [IDX_W-1:0] base;
    logic [2*N-1:0]   dbl;
    logic [N-1:0]     rot;
    logic [IDX_W-1:0] off;
    logic [IDX_W:0]   sum;

    // Rotate so the search always starts at bit 0, then un-rotate the offset.
    always_comb begin
        base = mode ? '0 : ptr;
        dbl  = {req, req} >> base;
        rot  = dbl[N-1:0];
        off  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) off = IDX_W'(k);
        end
        sum = {1'b0, base} + {1'b0, off};
        if (sum >= (IDX_W + 1)'(N)) sum = sum - (IDX_W + 1)'(N);
        winner = sum[IDX_W-1:0];
        valid  = |req;
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Single-channel memory-bus arbiter: grants one core at a time over the
// four-phase mem_ready handshake, muxes its request, and times out hung transfers.
module mem_bus_arbiter
    import mem_bus_arb_pkg::*;
#(
    parameter  int NUM_CORES      = 4,
    parameter  int ADDR_WIDTH     = 30,
    parameter  int DATA_WIDTH     = 32,
    parameter  int ARB_MODE       = 0,
    parameter  int TIMEOUT_CYCLES = 1024,
    localparam int OWNER_BITS     = owner_bits(NUM_CORES),
    localparam int BE_W           = DATA_WIDTH / 8
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic [NUM_CORES-1:0]                  core_req,
    input  logic [NUM_CORES-1:0]                  core_read,
    input  logic [NUM_CORES-1:0][BE_W-1:0]        core_write,
    input  logic [NUM_CORES-1:0][ADDR_WIDTH-1:0]  core_addr,
    input  logic [NUM_CORES-1:0][DATA_WIDTH-1:0]  core_wdata,
    output logic [NUM_CORES-1:0]                  core_grant,
    output logic [NUM_CORES-1:0]                  core_ready,
    input  logic                                  mem_ready,
    output logic                                  mem_read,
    output logic [BE_W-1:0]                       mem_write,
    output logic [ADDR_WIDTH-1:0]                 mem_addr,
    output logic [DATA_WIDTH-1:0]                 mem_wdata,
    output logic                                  busy,
    output logic [OWNER_BITS-1:0]                 owner,
    output logic                                  timeout_err,
    output logic [OWNER_BITS-1:0]                 err_owner
);

    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMO_LAST =
        TMR_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit WDOG_EN = (TIMEOUT_CYCLES != 0);

    arb_state_e            state;
    logic [OWNER_BITS-1:0] rr_ptr;
    logic [OWNER_BITS-1:0] ptr_next;
    logic [TMR_W-1:0]      timer;
    logic [OWNER_BITS-1:0] pick_idx;
    logic                  pick_vld;

    rr_pick #(.N(NUM_CORES), .IDX_W(OWNER_BITS)) u_pick (
        .req    (core_req),
        .ptr    (rr_ptr),
        .mode   (ARB_MODE == ARB_FIXED),
        .winner (pick_idx),
        .valid  (pick_vld)
    );

    always_comb begin
        ptr_next = rr_ptr;
        if (ARB_MODE == ARB_RR)
            ptr_next = (owner == OWNER_BITS'(NUM_CORES - 1)) ? '0 : owner + 1'b1;
    end

    assign busy       = (state != S_IDLE);
    assign core_ready = {NUM_CORES{mem_ready}} & core_grant;

    // Grant is one-hot or zero, so an AND-OR mux yields zeros when idle.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (core_grant[i]) begin
                mem_read  |= core_read[i];
                mem_write |= core_write[i];
                mem_addr  |= core_addr[i];
                mem_wdata |= core_wdata[i];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= S_IDLE;
            core_grant  <= '0;
            rr_ptr      <= '0;
            owner       <= '0;
            err_owner   <= '0;
            timeout_err <= 1'b0;
            timer       <= '0;
        end else begin
            timeout_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pick_vld) begin
                        owner <= pick_idx;
                        state <= S_SYNC;
                    end
                end
                S_SYNC: begin
                    if (!mem_ready) begin
                        core_grant <= NUM_CORES'(1) << owner;
                        timer      <= '0;
                        state      <= S_WAIT_ACK;
                    end
                end
                S_WAIT_ACK: begin
                    if (mem_ready) begin
                        state <= S_WAIT_REL;
                    end else if (WDOG_EN && timer == TMO_LAST) begin
                        core_grant  <= '0;
                        timeout_err <= 1'b1;
                        err_owner   <= owner;
                        state       <= S_DRAIN;
                    end else if (timer != '1) begin
                        timer <= timer + 1'b1;
                    end
                end
                S_WAIT_REL: begin
                    if (!core_req[owner]) state <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (!mem_ready) begin
                        core_grant <= '0;
                        rr_ptr     <= ptr_next;
                        state      <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (!core_req[owner]) begin
                        rr_ptr <= ptr_next;
                        state  <= S_IDLE;
                    end
                end
                default: begin
                    core_grant <= '0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Parametrised single-channel memory-bus arbiter and request mux for the multicore MIPS32 system.
- One instance serves the data bus and a second instance, with its write port tied off, serves the instruction bus.
- Grants one core at a time using round-robin or fixed priority, over the four-phase memory-ready handshake.
- Muxes the owner's request onto the memory bus, drives zeros when idle, and releases a hung transfer after a watchdog timeout.

Parameters:
- NUM_CORES, default 4: number of requesting cores; legal range 1..16.
- ADDR_WIDTH, default 30: word-address width.
- DATA_WIDTH, default 32: write-data width; must be a multiple of 8.
- ARB_MODE, default 0: 0 = round-robin, 1 = fixed priority (lowest index wins).
- TIMEOUT_CYCLES, default 1024: maximum cycles from grant to mem_ready high; 0 disables the watchdog.

Ports:
- clock  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- core_req  in  NUM_CORES  per-core bus request, held through the transfer.
- core_read  in  NUM_CORES  per-core read strobe.
- core_write  in  NUM_CORES*DATA_WIDTH/8  per-core byte write enables; core i occupies slice i.
- core_addr  in  NUM_CORES*ADDR_WIDTH  per-core address; core i occupies slice i.
- core_wdata  in  NUM_CORES*DATA_WIDTH  per-core write data.
- core_grant  out  NUM_CORES  one-hot grant, registered.
- core_ready  out  NUM_CORES  mem_ready gated by core_grant[i].
- mem_ready  in  1  memory ready/acknowledge.
- mem_read  out  1  muxed read strobe.
- mem_write  out  DATA_WIDTH/8  muxed byte write enables.
- mem_addr  out  ADDR_WIDTH  muxed address.
- mem_wdata  out  DATA_WIDTH  muxed write data.
- busy  out  1  high in every state except S_IDLE.
- owner  out  OWNER_BITS  index of the latched winner; valid while busy.
- timeout_err  out  1  one-cycle pulse when the watchdog fires.
- err_owner  out  OWNER_BITS  index of the last core that timed out; holds its value until the next timeout.

Behaviour:
- OWNER_BITS = max(1, $clog2(NUM_CORES)).
- Reset (reset==0 at a clock edge): state S_IDLE, core_grant=0, rr_ptr=0, owner=0, err_owner=0, timeout_err=0, timer=0. All mem_* outputs are 0.
- Mux: purely combinational from the registered core_grant. When core_grant==0, all mem_* outputs are 0; the block never drives z. The pass-through from core inputs to mem_* has zero-cycle latency while granted.
- core_ready[i] = mem_ready & core_grant[i].
- Winner selection in S_IDLE:
  - Round-robin: the first set core_req bit at index >= rr_ptr, wrapping modulo NUM_CORES, found in a single cycle. Idle cores are never polled one per cycle.
  - Fixed priority: the lowest set index.
- States:
  - S_IDLE: if any core_req is set, latch winner into owner and go to S_SYNC; otherwise stay.
  - S_SYNC: wait for mem_ready==0. Then set core_grant[owner]<=1, clear timer, go to S_WAIT_ACK. Grant is first visible 1 cycle after mem_ready is seen low.
  - S_WAIT_ACK: if mem_ready==1, go to S_WAIT_REL. Else if TIMEOUT_CYCLES!=0 and timer==TIMEOUT_CYCLES-1: core_grant<=0, timeout_err<=1 for one cycle, err_owner<=owner, go to S_DRAIN. Else timer increments.
  - S_WAIT_REL: if core_req[owner]==0, go to S_WAIT_DONE. Grant stays high.
  - S_WAIT_DONE: if mem_ready==0, core_grant<=0, go to S_IDLE, and in round-robin mode rr_ptr<=(owner+1) mod NUM_CORES.
  - S_DRAIN: grant is already low. If core_req[owner]==0, go to S_IDLE and update rr_ptr exactly as in S_WAIT_DONE.
- Boundary conditions:
  - A request arriving or dropping for a non-owner mid-transfer is ignored until S_IDLE.
  - The owner dropping core_req while in S_WAIT_ACK is ignored; the block waits for ack or timeout.
  - rr_ptr wraps from NUM_CORES-1 to 0.
  - NUM_CORES==1: core 0 is always the winner and rr_ptr stays 0.
  - The timer saturates and never wraps.
  - Reset mid-transfer drops the grant at that edge; the next edge with reset high starts from S_IDLE.
  - mem_ready already low on entry to S_SYNC: the grant is issued on the next edge.

Decomposition:
- Package mem_bus_arb_pkg holds:
  - state encoding constants S_IDLE..S_DRAIN, 3 bits;
  - ARB_RR and ARB_FIXED constants;
  - a function computing OWNER_BITS.
- Sub-module rr_pick: combinational; inputs req vector, ptr and mode; outputs winner index and a valid flag. It is reused by later interconnect blocks.

Test Plan:
- Reset check: hold reset=0 for 3 cycles with core_req=4'b1111 -> core_grant=0, mem_addr=0, busy=0; after reset is released, grant goes to core 0.
- Round-robin order: core_req=4'b1111 held, memory acks every transfer and each core drops its request after ack -> grant order 0,1,2,3,0; each grant is one-hot.
- Skip idle cores: rr_ptr=1, core_req=4'b1000 -> owner=3 one cycle after the request, with no per-core scan delay.
- Fixed priority: ARB_MODE=1, core 2 holds its request, core 0 requests mid-transfer -> core 0 is granted after core 2 completes, before core 3.
- Mux path: core 1 granted with addr=30'h0000_1234, wdata=32'hDEAD_BEEF, write=4'b1111 -> identical values on mem_* in the same cycle; zeros after completion.
- Watchdog: TIMEOUT_CYCLES=8, mem_ready stuck low -> after 8 cycles in S_WAIT_ACK, timeout_err pulses, err_owner=owner, grant drops; the block returns to S_IDLE after core_req drops.
